clk_div_bank: RTL

- Bank of CH independent programmable clock dividers; each channel generates a divided clock-enable waveform with programmable period and high time.
- Each channel also generates a one-cycle start-of-period tick.
- Reprogramming is glitch-free: new settings are double-buffered and take effect only at a period boundary.
- Sits between the system clock and the display/scan/tone logic, replacing per-use single dividers.

---
 rtl/clk_div_bank.sv | 82 ++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock-enable dividers with per-channel
// start-of-period tick and double-buffered, boundary-applied reprogramming.
module clk_div_bank #(
    parameter int unsigned     CH    = 4,
    parameter int unsigned     W     = 32,
    parameter logic [W-1:0]    DEF_N = W'(32'd50000000),
    parameter logic [W-1:0]    DEF_H = W'(32'd25000000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH-1:0]     en,
    input  logic [CH-1:0]     load,
    input  logic [CH*W-1:0]   div_n,
    input  logic [CH*W-1:0]   div_h,
    output logic [CH-1:0]     fout,
    output logic [CH-1:0]     tick,
    output logic [CH-1:0]     pend
);

    localparam logic [W-1:0] ONE  = W'(1'b1);
    localparam logic [W-1:0] ZERO = W'(1'b0);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] count_r;
        logic [W-1:0] act_n_r;
        logic [W-1:0] act_h_r;
        logic [W-1:0] pnd_n_r;
        logic [W-1:0] pnd_h_r;
        logic         pend_r;
        logic         fout_r;
        logic         tick_r;
        logic         run_s;
        logic         wrap_s;
        logic         apply_s;

        // A disabled or zero-period channel counts as a boundary every cycle.
        always_comb begin
            run_s   = en[i] && (act_n_r != ZERO);
            wrap_s  = (count_r >= act_n_r);
            apply_s = pend_r && (wrap_s || !run_s);
        end

        // Settings, counter and registered outputs for this channel.
        always_ff @(posedge clk) begin
            if (reset) begin
                count_r <= ONE;
                act_n_r <= DEF_N;
                act_h_r <= DEF_H;
                pnd_n_r <= ZERO;
                pnd_h_r <= ZERO;
                pend_r  <= 1'b0;
                fout_r  <= 1'b0;
                tick_r  <= 1'b0;
            end else begin
                if (apply_s) begin
                    act_n_r <= pnd_n_r;
                    act_h_r <= pnd_h_r;
                end
                // A load in the applying cycle re-arms pending with the new slice.
                if (load[i]) begin
                    pnd_n_r <= div_n[i*W +: W];
                    pnd_h_r <= div_h[i*W +: W];
                    pend_r  <= 1'b1;
                end else if (apply_s) begin
                    pend_r  <= 1'b0;
                end
                if (apply_s || !run_s || wrap_s) begin
                    count_r <= ONE;
                end else begin
                    count_r <= count_r + ONE;
                end
                fout_r <= run_s && (count_r <= act_h_r);
                tick_r <= run_s && (count_r == ONE);
            end
        end

        assign fout[i] = fout_r;
        assign tick[i] = tick_r;
        assign pend[i] = pend_r;
    end

endmodule
